// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline: next-PC select codes,
// the bubble instruction, fetch FSM states and opcodes used by the hazard unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_IS = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying instruction, PC, PC+4 and valid between stages.
// clear loads a bubble and takes priority over en; reset state is also a bubble.
import cpu_pkg::*;

module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pc4,
  input  logic [31:0] fetch_is,
  input  logic        fetch_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_is,
  output logic        id_valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      id_pc    <= 32'd0;
      id_pc4   <= 32'd4;
      id_is    <= NOP_IS;
      id_valid <= 1'b0;
    end else if (en) begin
      id_pc    <= fetch_pc;
      id_pc4   <= fetch_pc4;
      id_is    <= fetch_is;
      id_valid <= fetch_valid;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, debug halt/step FSM and IF/ID.
// Define IF_PERF_CNT_EN to add saturating fetch/stall/flush counters.
import cpu_pkg::*;

module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic [1:0]  npc_mux_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic        dbg_halt,
  input  logic        dbg_step,
  output logic [31:0] im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_is,
  output logic        id_valid,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc4;
  logic [31:0]  raw_target;
  logic [31:0]  redirect_pc;
  logic         redirect;
  logic         adv;
  logic         fetch;
  logic         stall;

  assign pc4      = pc + 32'd4;
  assign redirect = (npc_mux_sel != NPC_PC4);
  assign adv      = (state == RUN) || (state == HALT && dbg_step);
  assign fetch    = !redirect && adv && pc_en && if_id_en;
  assign stall    = !redirect && adv && !pc_en && !if_id_en;
  assign im_addr  = pc;
  assign if_pc    = pc;

  always_comb begin
    raw_target = pc4;
    unique case (npc_sel_t'(npc_mux_sel))
      NPC_BR:   raw_target = br_target;
      NPC_JAL:  raw_target = jal_target;
      NPC_JALR: raw_target = jalr_target & ~32'd1;
      default:  raw_target = pc4;
    endcase
    redirect_pc = {raw_target[31:2], 2'b00};
  end

  // A redirect comes from an instruction already in EX, so it beats stalls and halt.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= PC_RESET;
    else if (redirect)
      pc <= redirect_pc;
    else if (fetch)
      pc <= pc4;
  end

  // The halt request is registered: the cycle that raises it still fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: if (dbg_halt) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        HALT: if (!dbg_halt) begin
          state  <= RUN;
          halted <= 1'b0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (pc_en || !if_id_en);
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .en          (fetch),
    .clear       (redirect),
    .fetch_pc    (pc),
    .fetch_pc4   (pc4),
    .fetch_is    (im_dout),
    .fetch_valid (1'b1),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_is       (id_is),
    .id_valid    (id_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (fetch)    fetch_cnt <= sat_inc(fetch_cnt);
      if (stall)    stall_cnt <= sat_inc(stall_cnt);
      if (redirect) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] PC0 = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, pc_en, if_id_en, dbg_halt, dbg_step;
  logic [1:0]  npc_mux_sel;
  logic [31:0] br_target, jal_target, jalr_target;
  logic [31:0] im_addr, im_dout, if_pc, id_pc, id_pc4, id_is;
  logic        id_valid, halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  // Behavioural view: a program counter, the instruction last handed to decode,
  // and whether the debugger is holding fetch.
  logic [31:0] m_pc, m_is, m_id_pc, m_id_pc4;
  logic        m_valid, m_halted;
  logic [31:0] m_fetches, m_stalls, m_flushes;

  always #5 clk = ~clk;

  // Word i of the ROM (byte address PC0 + 4*i) holds the value i.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr - PC0) >> 2;
  endfunction

  assign im_dout = rom_word(im_addr);

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .npc_mux_sel (npc_mux_sel),
    .br_target   (br_target),
    .jal_target  (jal_target),
    .jalr_target (jalr_target),
    .dbg_halt    (dbg_halt),
    .dbg_step    (dbg_step),
    .im_addr     (im_addr),
    .im_dout     (im_dout),
    .if_pc       (if_pc),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_is       (id_is),
    .id_valid    (id_valid),
    .halted      (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cycle, obs, exp);
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_edge();
    logic [31:0] tgt;
    logic        may_fetch;
    if (rst) begin
      m_pc = PC0; m_is = NOP; m_id_pc = 0; m_id_pc4 = 4; m_valid = 0; m_halted = 0;
      m_fetches = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    may_fetch = !m_halted || dbg_step;
    if (npc_mux_sel != 2'b00) begin
      if (npc_mux_sel == 2'b01)      tgt = br_target;
      else if (npc_mux_sel == 2'b10) tgt = jal_target;
      else                           tgt = jalr_target;
      m_pc = tgt - (tgt % 4);
      m_is = NOP; m_id_pc = 0; m_id_pc4 = 4; m_valid = 0;
      m_flushes = bump(m_flushes);
    end else if (may_fetch && pc_en && if_id_en) begin
      m_is = rom_word(m_pc); m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4;
      m_fetches = bump(m_fetches);
    end else if (may_fetch && !pc_en && !if_id_en) begin
      m_stalls = bump(m_stalls);
    end
    m_halted = dbg_halt;
  endtask

  task automatic compare_all();
    check_output("im_addr", im_addr, m_pc);
    check_output("if_pc", if_pc, m_pc);
    check_output("id_is", id_is, m_is);
    check_output("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    check_output("halted", {31'd0, halted}, {31'd0, m_halted});
    if (m_valid) begin
      check_output("id_pc", id_pc, m_id_pc);
      check_output("id_pc4", id_pc4, m_id_pc4);
    end
`ifdef IF_PERF_CNT_EN
    check_output("fetch_cnt", fetch_cnt, m_fetches);
    check_output("stall_cnt", stall_cnt, m_stalls);
    check_output("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  task automatic apply_stimulus(input logic r, input logic pe, input logic ie, input logic [1:0] sel,
                                input logic [31:0] br, input logic [31:0] jal, input logic [31:0] jalr,
                                input logic hlt, input logic stp);
    rst = r; pc_en = pe; if_id_en = ie; npc_mux_sel = sel;
    br_target = br; jal_target = jal; jalr_target = jalr;
    dbg_halt = hlt; dbg_step = stp;
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    compare_all();
  endtask

  task automatic run_cycle();
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [1:0]  sel;
    logic        stall_now, halt_lvl;
    halt_lvl = 0;
    apply_stimulus(1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    check_output("reset_pc", if_pc, 32'h0000_3000);
    check_output("reset_is", id_is, 32'h0000_0013);
    check_output("reset_pc4", id_pc4, 32'd4);

    run_cycle(); run_cycle();
    check_output("free_run_pc", if_pc, 32'h0000_3008);
    check_output("free_run_is", id_is, 32'd1);

    apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check_output("stall_pc", if_pc, 32'h0000_3008);
    run_cycle();
    check_output("resume_pc", if_pc, 32'h0000_300C);

    apply_stimulus(0, 1, 1, 2'b01, 32'h0000_3100, 0, 0, 0, 0);
    check_output("branch_pc", if_pc, 32'h0000_3100);
    check_output("branch_bubble", id_is, 32'h0000_0013);
    run_cycle();
    check_output("branch_fetch", id_is, 32'h0000_0040);

    apply_stimulus(0, 0, 0, 2'b11, 0, 0, 32'h0000_3201, 0, 0);
    check_output("jalr_pc", if_pc, 32'h0000_3200);
    run_cycle(); run_cycle(); run_cycle(); run_cycle();

    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 1, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 1, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 1, 1);
    check_output("step_pc", if_pc, 32'h0000_3218);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 1, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 0, 1, 0);
    check_output("halt_hold_pc", if_pc, 32'h0000_3218);
    run_cycle(); run_cycle();

    apply_stimulus(1, 1, 1, 2'b10, 0, 32'h0000_5000, 0, 0, 0);
    check_output("rst_redirect_pc", if_pc, 32'h0000_3000);

    for (int i = 0; i < 400; i++) begin
      sel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      stall_now = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) halt_lvl = !halt_lvl;
      apply_stimulus($urandom_range(0, 59) == 0, !stall_now, !stall_now, sel,
                     $urandom, $urandom, $urandom, halt_lvl, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
